uart_boot_loader: RTL

//  Serial program loader and bus initiator on the CPU/memory bus. Receives a framed

---
 rtl/uart_boot_loader_if.sv | 9 +
 rtl/uart_boot_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader_if.sv
// Memory write bus driven by the boot loader while it holds the core in reset.
interface uart_boot_loader_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  modport master (output MemWrite, output DataAdr, output WriteData);
  modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) image loader: A5, LEN_LO, LEN_HI, LEN little-endian words -> memory writes.
// Optional trailing XOR checksum byte enabled by defining UART_BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  uart_boot_loader_if.master bus,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  // ---------------- RX front end ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

  logic [2:0]    rx_pipe;   // [1] synchronised rx, [2] its previous value
  rx_st_t        rx_st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_pipe    <= 3'b111;
      rx_st      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_pipe    <= {rx_pipe[1:0], rx};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_st)
        RX_IDLE: if (rx_pipe[2] && !rx_pipe[1]) begin
          cnt   <= '0;
          rx_st <= RX_START;
        end
        RX_START: if (cnt == CW'(HALF - 1)) begin
          // a start bit that is high again at mid-bit was a glitch
          cnt     <= '0;
          bit_idx <= '0;
          rx_st   <= rx_pipe[1] ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + CW'(1);
        RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt     <= '0;
          shreg   <= {rx_pipe[1], shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_st <= RX_STOP;
        end else cnt <= cnt + CW'(1);
        RX_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt   <= '0;
          rx_st <= RX_IDLE;
          if (rx_pipe[1]) begin
            byte_valid <= 1'b1;
            rx_byte    <= shreg;
          end else begin
            frame_err  <= 1'b1;
          end
        end else cnt <= cnt + CW'(1);
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- loader FSM ----------------
  typedef enum logic [2:0] {SYNC, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR} ld_st_t;

  ld_st_t      st;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  k;
  logic [31:0] word;
  logic [16:0] len_new;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign len_new = {1'b0, rx_byte, len[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= SYNC;
      len           <= '0;
      idx           <= '0;
      k             <= '0;
      word          <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum          <= '0;
`endif
      bus.MemWrite  <= 1'b0;
      bus.DataAdr   <= BASE_ADDR;
      bus.WriteData <= '0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.MemWrite <= 1'b0;
      if (frame_err && st != DONE && st != ERROR) begin
        st    <= ERROR;
        error <= 1'b1;
      end else begin
        case (st)
          SYNC:   if (byte_valid && rx_byte == 8'hA5) st <= LEN_LO;
          LEN_LO: if (byte_valid) begin
            len[7:0] <= rx_byte;
            st       <= LEN_HI;
          end
          LEN_HI: if (byte_valid) begin
            len[15:8] <= rx_byte;
            idx       <= '0;
            k         <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
            csum      <= '0;
`endif
            if (len_new > 17'(MAX_WORDS)) begin
              st    <= ERROR;
              error <= 1'b1;
            end else if (len_new == '0) begin
`ifdef UART_BOOT_CHECKSUM_EN
              st        <= CHK;
`else
              st        <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else begin
              st <= DATA;
            end
          end
          DATA: if (byte_valid) begin
            word <= {rx_byte, word[31:8]};
            k    <= k + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
            csum <= csum ^ rx_byte;
`endif
            if (k == 2'd3) begin
              st            <= WRITE;
              bus.MemWrite  <= 1'b1;
              bus.DataAdr   <= BASE_ADDR + {14'b0, idx, 2'b00};
              bus.WriteData <= {rx_byte, word[31:8]};
            end
          end
          WRITE: begin
            idx <= idx + 16'd1;
            if (idx + 16'd1 == len) begin
`ifdef UART_BOOT_CHECKSUM_EN
              st        <= CHK;
`else
              st        <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
`endif
            end else begin
              st <= DATA;
            end
          end
`ifdef UART_BOOT_CHECKSUM_EN
          CHK: if (byte_valid) begin
            if (rx_byte == csum) begin
              st        <= DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              st    <= ERROR;
              error <= 1'b1;
            end
          end
`endif
          default: ;  // DONE, ERROR: sticky until reset
        endcase
      end
    end
  end

endmodule
